// File: rtl/integ_capture_fifo.sv
// First-word-fall-through FIFO that captures integrator window sums with their averages.
// Optional build macro INTEG_AVG_ROUND_EN selects round-half-up, saturating averaging.
module integ_capture_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     win_done,
    input  logic [12:0]              sum_in,
    output logic [12:0]              out_sum,
    output logic [9:0]               out_avg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [12:0] sum;
        logic [9:0]  avg;
    } entry_t;

    function automatic logic [9:0] window_avg(input logic [12:0] s);
`ifdef INTEG_AVG_ROUND_EN
        logic [13:0] biased;
        biased = {1'b0, s} + 14'd4;
        // A carry into bit 13 means the shifted result reached 1024.
        if (biased[13])
            window_avg = 10'h3FF;
        else
            window_avg = biased[12:3];
`else
        window_avg = s[12:3];
`endif
    endfunction

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic            drop_reg;
    logic            valid_reg;
    entry_t          head_reg;

    logic            push;
    logic            pop;
    logic            full;
    logic            do_write;
    entry_t          push_entry;
    logic [AW-1:0]   wr_ptr_next;
    logic [AW-1:0]   rd_ptr_next;
    logic [LW-1:0]   level_next;
    logic            drop_next;
    entry_t          head_next;

    assign push       = win_done;
    assign pop        = valid_reg & out_ready;
    assign full       = (level_reg == LW'(DEPTH));
    assign do_write   = push & (~full | pop);
    assign push_entry = '{sum: sum_in, avg: window_avg(sum_in)};

    always_comb begin
        wr_ptr_next = wr_ptr_reg + AW'(do_write);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        level_next  = level_reg + LW'(do_write) - LW'(pop);
        drop_next   = drop_reg | (push & full & ~pop);
    end

    // The next head is the entry being written this edge only when nothing older survives.
    always_comb begin
        head_next = '0;
        if (level_next != '0) begin
            if (do_write && (wr_ptr_reg == rd_ptr_next))
                head_next = push_entry;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            drop_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            drop_reg   <= drop_next;
            valid_reg  <= (level_next != '0);
            head_reg   <= head_next;
        end
    end

    assign out_sum   = head_reg.sum;
    assign out_avg   = head_reg.avg;
    assign out_valid = valid_reg;
    assign level     = level_reg;
    assign drop      = drop_reg;

endmodule

// File: doc/integ_capture_fifo.md
INTEG_CAPTURE_FIFO -- requirements
Module: integ_capture_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries; power of two, 2..16.
REQ-002 Port: clk  input  1  rising-edge clock shared with the upstream integrator.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: win_done  input  1  one-cycle pulse marking the last cycle of an integration window.
REQ-005 Port: sum_in  input  13  accumulated window sum from the integrator; valid when win_done=1.
REQ-006 Port: out_sum  output  13  head-of-FIFO raw window sum.
REQ-007 Port: out_avg  output  10  head-of-FIFO window average.
REQ-008 Port: out_valid  output  1  FIFO non-empty; out_sum and out_avg are valid.
REQ-009 Port: out_ready  input  1  consumer accepts the head entry when out_valid=1 and out_ready=1.
REQ-010 Port: level  output  clog2(DEPTH)+1  current number of stored entries.
REQ-011 Port: drop  output  1  sticky flag: at least one window was lost because the FIFO was full.

Function
REQ-012 On a rising clk with win_done=1, the block SHALL push sum_in together with avg(sum_in) as one entry.
REQ-013 avg(s) SHALL be floor(s/8), i.e. s[12:3], unless the rounding feature (REQ-027) is compiled in.
REQ-014 A pop SHALL occur on a rising clk with out_valid=1 and out_ready=1; the head entry is removed.
REQ-015 The FIFO SHALL be first-word-fall-through: a push into an empty FIFO appears on out_sum/out_avg with out_valid=1 one cycle after the capture edge.
REQ-016 out_valid SHALL equal (level != 0); out_sum and out_avg SHALL be 0 whenever out_valid=0.
REQ-017 Full, push and pop in the same cycle: both SHALL occur; level stays DEPTH and nothing is dropped.
REQ-018 Full, push without pop: the new entry SHALL be discarded, stored data SHALL be unchanged, and drop SHALL be set.
REQ-019 Empty with push and pop asserted in the same cycle: the pop SHALL be ignored, since out_valid=0, and the push SHALL complete.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range from 0 to DEPTH inclusive.
REQ-021 Once set, drop SHALL be cleared only by reset.
REQ-022 A win_done held high for N consecutive cycles SHALL push N entries; the block does not detect pulse edges.

Reset
REQ-023 While reset=0, all pointers, level, drop, out_valid, out_sum and out_avg SHALL be 0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries; the first push after release SHALL become the head.
REQ-025 A win_done coinciding with the first rising clk after reset release SHALL be captured normally.
REQ-026 Storage array contents need not be reset; their values SHALL never be visible while out_valid=0.

Configuration
REQ-027 Macro INTEG_AVG_ROUND_EN:
- Defined: avg(s) SHALL be min((s+4)>>3, 1023), i.e. round-half-up with saturation.
- Undefined: avg(s) SHALL be floor(s/8).
- out_sum is unaffected in both cases.

Verification
REQ-028 Single window: after reset, sum_in=1625 with win_done pulse, out_ready=0 -> next cycle out_valid=1, out_sum=1625, out_avg=203 (rounded build: 203), level=1.
REQ-029 Rounding: sum_in=1628, then 8191 -> unrounded build out_avg=203, 1023; rounded build out_avg=204, 1023.
REQ-030 Fill/overflow at DEPTH=4: push 100, 200, 300, 400, 500 with out_ready=0 -> level=4, drop=1, pop order yields 100, 200, 300, 400; 500 is never output.
REQ-031 Full with simultaneous push and pop: FIFO holds 10, 20, 30, 40; push 50 with out_ready=1 -> level stays 4, drop stays 0, subsequent pops yield 20, 30, 40, 50.
REQ-032 Reset mid-operation: level=3, drop=1, assert reset between clock edges -> out_valid, level and drop go to 0 immediately; after release, push 75 -> out_sum=75, out_avg=9.
REQ-033 Pointer wrap: stream 10 windows with out_ready=1 continuously -> every sum appears exactly once, in order, with level never above 1.
